// File: rtl/adcsum_multi.sv
//------------------------------------------------------------------------------
// Module   : adcsum_multi
// Brief    : NCH-channel tagged ADC accumulator with latch-to-shadow snapshot and
//            valid/ready channel-by-channel readout. Optional: ADCSUM_SATURATE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adcsum_multi #(
  parameter int NCH         = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int SUM_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [$clog2(NCH)-1:0] channel,
  input  logic                   data_ready,
  input  logic                   signed_mode,
  input  logic                   gate,
  input  logic                   latch,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] q_channel,
  output logic [SUM_WIDTH-1:0]   q,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   overrun
);

  localparam int c_CHW = $clog2(NCH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CHW-1:0]       r_qch;
  logic                   r_overrun;

  logic [SUM_WIDTH-1:0]   r_sum  [NCH];
  logic [COUNT_WIDTH-1:0] r_cnt  [NCH];
  logic [SUM_WIDTH-1:0]   r_ssum [NCH];
  logic [COUNT_WIDTH-1:0] r_scnt [NCH];

  logic                   w_acc;
  logic                   w_take;
  logic                   w_last;
  logic [SUM_WIDTH-1:0]   w_ext;
  logic [SUM_WIDTH-1:0]   w_cur;
  logic [SUM_WIDTH-1:0]   w_sum_next;
  logic [COUNT_WIDTH-1:0] w_cnt_next;

  assign w_acc  = data_ready & gate;
  assign w_take = (r_state == S_IDLE) & latch;
  assign w_last = (r_qch == c_CHW'(NCH - 1));

  assign w_ext = signed_mode ? {{(SUM_WIDTH-DATA_WIDTH){data[DATA_WIDTH-1]}}, data}
                             : {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, data};
  assign w_cur = r_sum[channel];

`ifdef ADCSUM_SATURATE_EN
  logic [SUM_WIDTH:0] w_wide;
  logic               w_sovf;

  assign w_wide = {1'b0, w_cur} + {1'b0, w_ext};
  // Signed overflow: operands agree in sign but the result does not.
  assign w_sovf = (w_cur[SUM_WIDTH-1] == w_ext[SUM_WIDTH-1]) &&
                  (w_wide[SUM_WIDTH-1] != w_cur[SUM_WIDTH-1]);

  always_comb begin
    w_sum_next = w_wide[SUM_WIDTH-1:0];
    if (signed_mode) begin
      if (w_sovf) begin
        w_sum_next = w_cur[SUM_WIDTH-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                        : {1'b0, {(SUM_WIDTH-1){1'b1}}};
      end
    end else if (w_wide[SUM_WIDTH]) begin
      w_sum_next = {SUM_WIDTH{1'b1}};
    end
  end
`else
  assign w_sum_next = w_cur + w_ext;
`endif

  assign w_cnt_next = (r_cnt[channel] == {COUNT_WIDTH{1'b1}}) ? r_cnt[channel]
                                                               : r_cnt[channel] + 1'b1;

  // Live accumulators and shadow bank; a sample coincident with an accepted
  // latch starts the new window instead of landing in the snapshot.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < NCH; i++) begin
        r_sum[i]  <= '0;
        r_cnt[i]  <= '0;
        r_ssum[i] <= '0;
        r_scnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_take) begin
          r_ssum[i] <= r_sum[i];
          r_scnt[i] <= r_cnt[i];
          r_sum[i]  <= '0;
          r_cnt[i]  <= '0;
        end
        if (w_acc && (channel == c_CHW'(i))) begin
          r_sum[i] <= w_take ? w_ext : w_sum_next;
          r_cnt[i] <= w_take ? COUNT_WIDTH'(1) : w_cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (latch) w_state_nxt = S_SEND;
      S_SEND:  if (out_ready && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_qch     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= latch & (r_state == S_SEND);
      if (w_take) begin
        r_qch <= '0;
      end else if ((r_state == S_SEND) && out_ready) begin
        r_qch <= w_last ? '0 : r_qch + 1'b1;
      end
    end
  end

  assign out_valid = (r_state == S_SEND);
  assign busy      = (r_state == S_SEND);
  assign overrun   = r_overrun;
  assign q_channel = r_qch;
  assign q         = r_ssum[r_qch];
  assign count     = r_scnt[r_qch];

endmodule

`default_nettype wire

// File: tb/tb_adcsum_multi.sv
//------------------------------------------------------------------------------
// Module   : tb_adcsum_multi
// Brief    : Directed self-checking bench for adcsum_multi (default and 20/4-bit
//            instances). Expectations follow ADCSUM_SATURATE_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adcsum_multi;

  logic        clk = 1'b0;
  logic        sclr, data_ready, signed_mode, gate, latch, out_ready;
  logic [15:0] data;
  logic [1:0]  channel;

  logic        out_valid, busy, overrun;
  logic [1:0]  q_channel;
  logic [31:0] q;
  logic [15:0] count;

  logic        out_valid2, busy2, overrun2;
  logic [1:0]  q_channel2;
  logic [19:0] q2;
  logic [3:0]  count2;

  int checks   = 0;
  int failures = 0;

  adcsum_multi #(.NCH(4), .DATA_WIDTH(16), .SUM_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .sclr(sclr), .data(data), .channel(channel), .data_ready(data_ready),
    .signed_mode(signed_mode), .gate(gate), .latch(latch), .out_ready(out_ready),
    .out_valid(out_valid), .q_channel(q_channel), .q(q), .count(count),
    .busy(busy), .overrun(overrun)
  );

  adcsum_multi #(.NCH(4), .DATA_WIDTH(16), .SUM_WIDTH(20), .COUNT_WIDTH(4)) dut2 (
    .clk(clk), .sclr(sclr), .data(data), .channel(channel), .data_ready(data_ready),
    .signed_mode(signed_mode), .gate(gate), .latch(latch), .out_ready(out_ready),
    .out_valid(out_valid2), .q_channel(q_channel2), .q(q2), .count(count2),
    .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] d;
    logic        sm;
  } smp_t;

  typedef struct {
    logic [31:0] q;
    logic [15:0] c;
  } wrd_t;

  smp_t        vec  [15];
  wrd_t        expw [3][4];
  logic [31:0] eq   [4];
  logic [15:0] ec   [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] ch, input logic [15:0] d, input logic sm);
    channel = ch; data = d; signed_mode = sm; data_ready = 1'b1; gate = 1'b1;
    step();
    data_ready = 1'b0; gate = 1'b0;
  endtask

  task automatic do_latch();
    latch = 1'b1;
    step();
    latch = 1'b0;
  endtask

  task automatic clr_exp();
    for (int k = 0; k < 4; k++) begin
      eq[k] = '0;
      ec[k] = '0;
    end
  endtask

  task automatic readout(input string nm, input bit latch_last);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_w%0d_valid", nm, k), out_valid, 1);
      chk($sformatf("%s_w%0d_ch", nm, k), q_channel, k);
      chk($sformatf("%s_w%0d_q", nm, k), q, eq[k]);
      chk($sformatf("%s_w%0d_cnt", nm, k), count, ec[k]);
      if (k == 3 && latch_last) latch = 1'b1;
      step();
      latch = 1'b0;
    end
    out_ready = 1'b0;
    chk($sformatf("%s_end_valid", nm), out_valid, 0);
    chk($sformatf("%s_end_busy", nm), busy, 0);
    if (latch_last) chk($sformatf("%s_last_overrun", nm), overrun, 1);
  endtask

  initial begin
    sclr = 1'b1; data_ready = 1'b0; signed_mode = 1'b0; gate = 1'b0;
    latch = 1'b0; out_ready = 1'b0; data = '0; channel = '0;

    vec[0]  = '{2'd0, 16'd2, 1'b0};     vec[1]  = '{2'd0, 16'd3, 1'b0};
    vec[2]  = '{2'd0, 16'd4, 1'b0};     vec[3]  = '{2'd0, 16'd5, 1'b0};
    vec[4]  = '{2'd0, 16'd6, 1'b0};
    vec[5]  = '{2'd2, 16'd2, 1'b1};     vec[6]  = '{2'd2, 16'd3, 1'b1};
    vec[7]  = '{2'd2, 16'd4, 1'b1};     vec[8]  = '{2'd2, 16'hfff8, 1'b1};
    vec[9]  = '{2'd2, 16'd6, 1'b1};
    vec[10] = '{2'd2, 16'd2, 1'b0};     vec[11] = '{2'd2, 16'd3, 1'b0};
    vec[12] = '{2'd2, 16'd4, 1'b0};     vec[13] = '{2'd2, 16'hfff8, 1'b0};
    vec[14] = '{2'd2, 16'd6, 1'b0};
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) expw[g][k] = '{32'd0, 16'd0};
    expw[0][0] = '{32'd20, 16'd5};
    expw[1][2] = '{32'd7, 16'd5};
    expw[2][2] = '{32'd65543, 16'd5};

    step(); step();
    sclr = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_qch", q_channel, 0);
    chk("rst_q", q, 0);
    chk("rst_count", count, 0);

    // Strobe with gate low must not accumulate.
    channel = 2'd0; data = 16'd100; data_ready = 1'b1; gate = 1'b0;
    step();
    data_ready = 1'b0;

    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 5; i++) feed(vec[g*5+i].ch, vec[g*5+i].d, vec[g*5+i].sm);
      do_latch();
      for (int k = 0; k < 4; k++) begin
        eq[k] = expw[g][k].q;
        ec[k] = expw[g][k].c;
      end
      readout($sformatf("grp%0d", g), 1'b0);
    end

    // Sample coincident with latch belongs to the new window; latch on final handshake rejected.
    feed(2'd1, 16'd5, 1'b0);
    channel = 2'd1; data = 16'd9; signed_mode = 1'b0;
    data_ready = 1'b1; gate = 1'b1; latch = 1'b1;
    step();
    data_ready = 1'b0; gate = 1'b0; latch = 1'b0;
    clr_exp(); eq[1] = 32'd5; ec[1] = 16'd1;
    readout("t3a", 1'b1);
    step();
    chk("t3_overrun_pulse", overrun, 0);
    do_latch();
    clr_exp(); eq[1] = 32'd9; ec[1] = 16'd1;
    readout("t3b", 1'b0);

    // Backpressure hold, latch during SEND gives overrun, accumulation continues.
    feed(2'd3, 16'd10, 1'b0);
    do_latch();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_hold%0d_valid", c), out_valid, 1);
      chk($sformatf("t4_hold%0d_ch", c), q_channel, 0);
      chk($sformatf("t4_hold%0d_q3", c), dut.r_ssum[3], 32'd10);
      if (c == 1) begin
        latch = 1'b1; channel = 2'd3; data = 16'd7; data_ready = 1'b1; gate = 1'b1;
      end
      step();
      latch = 1'b0; data_ready = 1'b0; gate = 1'b0;
      chk($sformatf("t4_hold%0d_overrun", c), overrun, (c == 1) ? 1 : 0);
    end
    clr_exp(); eq[3] = 32'd10; ec[3] = 16'd1;
    readout("t4a", 1'b0);
    do_latch();
    clr_exp(); eq[3] = 32'd7; ec[3] = 16'd1;
    readout("t4b", 1'b0);

    // sclr in the middle of readout.
    feed(2'd0, 16'd100, 1'b0);
    feed(2'd1, 16'd200, 1'b0);
    do_latch();
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    chk("t6_mid_ch", q_channel, 2);
    sclr = 1'b1; channel = 2'd2; data = 16'd50; data_ready = 1'b1; gate = 1'b1;
    step();
    sclr = 1'b0; data_ready = 1'b0; gate = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_qch", q_channel, 0);
    chk("t6_q", q, 0);
    chk("t6_count", count, 0);
    do_latch();
    clr_exp();
    readout("t6", 1'b0);

    // Narrow sum/count instance: wrap or clamp, and count saturation.
    sclr = 1'b1; step(); sclr = 1'b0;
    for (int i = 0; i < 17; i++) feed(2'd0, 16'hffff, 1'b0);
    do_latch();
`ifdef ADCSUM_SATURATE_EN
    chk("t5_q20", q2, 20'hfffff);
`else
    chk("t5_q20", q2, 20'd65519);
`endif
    chk("t5_cnt4", count2, 4'd15);
    chk("t5_q32", q, 32'd1114095);
    chk("t5_cnt16", count, 16'd17);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b0;
    chk("t5_end_valid", out_valid2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
